// File: rtl/julia_pkg.sv
// Shared types for the Julia-set frame scheduler: Q8.24 fixed point, config addresses, FSM states
// and the log-shading curve used by julia_shade_lut.
package julia_pkg;

  localparam int unsigned FRAC_BITS = 24;
  localparam int unsigned X_W       = 10;
  localparam int unsigned Y_W       = 9;

  typedef logic signed [31:0] fix_t;

  typedef enum logic [2:0] {
    CFG_C_RE   = 3'd0,
    CFG_C_IM   = 3'd1,
    CFG_RE_MIN = 3'd2,
    CFG_IM_MAX = 3'd3,
    CFG_STEP   = 3'd4
  } cfg_addr_e;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StIssue,
    StDrain,
    StDone
  } sched_state_e;

  // Piecewise-linear 32*log2(iter+1): integer part from the MSB, 5 fraction bits below it.
  function automatic logic [7:0] log_shade(input logic [7:0] iter);
    logic [8:0]  v;
    logic [3:0]  k;
    logic [13:0] norm;
    logic [8:0]  s;
    v = {1'b0, iter} + 9'd1;
    k = '0;
    for (int i = 0; i < 9; i++) begin
      if (v[i]) k = 4'(i);
    end
    norm = {v, 5'b0} >> k;
    s = {k, norm[4:0]};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/julia_shade_lut.sv
// Registered 256-entry log-shading ROM: iteration count in, 8-bit intensity out one cycle later.
module julia_shade_lut
  import julia_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] iter,
  output logic [7:0] shade
);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      shade <= '0;
    end else begin
      shade <= log_shade(iter);
    end
  end

endmodule

// File: rtl/julia_frame_sched.sv
// Julia-set frame scheduler: raster-scans the viewport, issues pixel jobs to the iteration engine
// and writes shaded results to the framebuffer. Define SMOOTH_SHADE_EN for log shading.
module julia_frame_sched
  import julia_pkg::*;
#(
  parameter int unsigned IMG_W     = 640,
  parameter int unsigned IMG_H     = 480,
  parameter int unsigned MAX_ITER  = 100,
  parameter int unsigned MAX_OUTST = 8,
  parameter int unsigned INT_SCALE = 2
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           cfg_we,
  input  logic [2:0]     cfg_addr,
  input  logic [31:0]    cfg_data,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic [15:0]    frame_cnt,
  output logic           job_valid,
  input  logic           job_ready,
  output logic [31:0]    job_z_re,
  output logic [31:0]    job_z_im,
  output logic [31:0]    job_c_re,
  output logic [31:0]    job_c_im,
  output logic [X_W-1:0] job_x,
  output logic [Y_W-1:0] job_y,
  input  logic           res_valid,
  output logic           res_ready,
  input  logic [7:0]     res_iter,
  input  logic [X_W-1:0] res_x,
  input  logic [Y_W-1:0] res_y,
  output logic           pix_we,
  output logic [X_W-1:0] pix_x,
  output logic [Y_W-1:0] pix_y,
  output logic [7:0]     pix_int
);

  localparam int unsigned    OW        = $clog2(MAX_OUTST + 1);
  localparam logic [X_W-1:0] X_LAST    = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0] Y_LAST    = Y_W'(IMG_H - 1);
  localparam logic [OW-1:0]  OUTST_MAX = OW'(MAX_OUTST);

  sched_state_e   state_q, state_d;
  fix_t           sh_c_re_q, sh_c_im_q, sh_re_min_q, sh_im_max_q, sh_step_q;
  fix_t           wk_c_re_q, wk_c_im_q, wk_re_min_q, wk_step_q;
  fix_t           z_re_q, z_im_q;
  logic [X_W-1:0] x_q;
  logic [Y_W-1:0] y_q;
  logic [OW-1:0]  outst_q;
  logic [15:0]    frame_cnt_q;
  logic           rdy_q;
  logic           pix_we_q;
  logic [X_W-1:0] pix_x_q;
  logic [Y_W-1:0] pix_y_q;
  logic [7:0]     pix_int_q;
  logic           job_fire, res_fire, last_pix, pix_pend, interior;

  assign job_valid = (state_q == StIssue) && (outst_q < OUTST_MAX);
  assign job_fire  = job_valid && job_ready;
  assign res_ready = rdy_q;
  assign res_fire  = res_valid && rdy_q;
  assign last_pix  = (x_q == X_LAST) && (y_q == Y_LAST);
  assign interior  = 32'(res_iter) >= MAX_ITER;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sh_c_re_q   <= '0;
      sh_c_im_q   <= '0;
      sh_re_min_q <= '0;
      sh_im_max_q <= '0;
      sh_step_q   <= '0;
    end else if (cfg_we) begin
      case (cfg_addr)
        CFG_C_RE:   sh_c_re_q   <= cfg_data;
        CFG_C_IM:   sh_c_im_q   <= cfg_data;
        CFG_RE_MIN: sh_re_min_q <= cfg_data;
        CFG_IM_MAX: sh_im_max_q <= cfg_data;
        CFG_STEP:   sh_step_q   <= cfg_data;
        default:    ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StLoad;
      StLoad:  state_d = StIssue;
      StIssue: if (job_fire && last_pix) state_d = StDrain;
      StDrain: if ((outst_q == '0) && !pix_pend) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= StIdle;
      outst_q     <= '0;
      rdy_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      if (state_q == StLoad) begin
        outst_q <= '0;
      end else if (job_fire && !res_fire) begin
        outst_q <= outst_q + OW'(1);
      end else if (!job_fire && res_fire) begin
        outst_q <= outst_q - OW'(1);
      end
      if (state_q == StDone) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  // Working copies are frozen for the whole frame so mid-frame config writes only hit the shadows.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wk_c_re_q   <= '0;
      wk_c_im_q   <= '0;
      wk_re_min_q <= '0;
      wk_step_q   <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_re_q      <= '0;
      z_im_q      <= '0;
    end else if (state_q == StLoad) begin
      wk_c_re_q   <= sh_c_re_q;
      wk_c_im_q   <= sh_c_im_q;
      wk_re_min_q <= sh_re_min_q;
      wk_step_q   <= sh_step_q;
      x_q         <= '0;
      y_q         <= '0;
      z_re_q      <= sh_re_min_q;
      z_im_q      <= sh_im_max_q;
    end else if (job_fire) begin
      if (x_q == X_LAST) begin
        x_q    <= '0;
        z_re_q <= wk_re_min_q;
        y_q    <= y_q + Y_W'(1);
        z_im_q <= z_im_q - wk_step_q;
      end else begin
        x_q    <= x_q + X_W'(1);
        z_re_q <= z_re_q + wk_step_q;
      end
    end
  end

`ifdef SMOOTH_SHADE_EN
  logic           s1_valid_q, s1_interior_q;
  logic [X_W-1:0] s1_x_q;
  logic [Y_W-1:0] s1_y_q;
  logic [7:0]     shade;

  julia_shade_lut u_shade_lut (
    .CLK  (CLK),
    .RESET(RESET),
    .iter (res_iter),
    .shade(shade)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1_valid_q    <= 1'b0;
      s1_interior_q <= 1'b0;
      s1_x_q        <= '0;
      s1_y_q        <= '0;
      pix_we_q      <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_int_q     <= '0;
    end else begin
      s1_valid_q <= res_fire;
      if (res_fire) begin
        s1_interior_q <= interior;
        s1_x_q        <= res_x;
        s1_y_q        <= res_y;
      end
      pix_we_q <= s1_valid_q;
      if (s1_valid_q) begin
        pix_x_q   <= s1_x_q;
        pix_y_q   <= s1_y_q;
        pix_int_q <= s1_interior_q ? 8'd0 : shade;
      end
    end
  end

  assign pix_pend = s1_valid_q;
`else
  logic [31:0] lin_prod;
  logic [7:0]  lin_int;

  assign lin_prod = 32'(res_iter) * INT_SCALE;
  assign lin_int  = interior ? 8'd0 : ((lin_prod > 32'd255) ? 8'hFF : lin_prod[7:0]);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pix_we_q  <= 1'b0;
      pix_x_q   <= '0;
      pix_y_q   <= '0;
      pix_int_q <= '0;
    end else begin
      pix_we_q <= res_fire;
      if (res_fire) begin
        pix_x_q   <= res_x;
        pix_y_q   <= res_y;
        pix_int_q <= lin_int;
      end
    end
  end

  assign pix_pend = 1'b0;
`endif

  assign busy      = (state_q == StLoad) || (state_q == StIssue) || (state_q == StDrain);
  assign done      = (state_q == StDone);
  assign frame_cnt = frame_cnt_q;
  assign job_z_re  = z_re_q;
  assign job_z_im  = z_im_q;
  assign job_c_re  = wk_c_re_q;
  assign job_c_im  = wk_c_im_q;
  assign job_x     = x_q;
  assign job_y     = y_q;
  assign pix_we    = pix_we_q;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign pix_int   = pix_int_q;

endmodule

// File: tb/tb_julia_frame_sched.sv
// Scoreboard bench for julia_frame_sched on a 4x3 frame: expected jobs and pixels are queued as
// stimulus is issued; a negedge monitor pops and compares whenever the DUT presents them.
`timescale 1ns/1ps
module tb_julia_frame_sched;
  import julia_pkg::*;

  localparam int W = 4;
  localparam int H = 3;
  localparam int NPIX = W * H;
  localparam int OUTST = 8;
  localparam int EngNormal = 0;
  localparam int EngHold = 1;
  localparam int EngReverse = 2;
  localparam int EngStop4 = 3;

  typedef struct packed {
    logic [9:0]  x;
    logic [8:0]  y;
    logic [31:0] z_re;
    logic [31:0] z_im;
    logic [31:0] c_re;
    logic [31:0] c_im;
  } job_t;
  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [7:0] it;
  } pix_t;
  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
  } tag_t;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic cfg_we = 1'b0;
  logic [2:0] cfg_addr = '0;
  logic [31:0] cfg_data = '0;
  logic start = 1'b0;
  logic busy, done, job_valid, res_ready, pix_we;
  logic [15:0] frame_cnt;
  logic job_ready = 1'b0;
  logic [31:0] job_z_re, job_z_im, job_c_re, job_c_im;
  logic [9:0] job_x, pix_x;
  logic [8:0] job_y, pix_y;
  logic res_valid = 1'b0;
  logic [7:0] res_iter = '0;
  logic [9:0] res_x = '0;
  logic [8:0] res_y = '0;
  logic [7:0] pix_int;

  // Second instance with INT_SCALE=4, only its result path is exercised.
  logic res_valid4 = 1'b0;
  logic [7:0] res_iter4 = '0;
  logic [9:0] res_x4 = '0;
  logic [8:0] res_y4 = '0;
  logic busy4, done4, job_valid4, res_ready4, pix_we4;
  logic [15:0] frame_cnt4;
  logic [31:0] job_z_re4, job_z_im4, job_c_re4, job_c_im4;
  logic [9:0] job_x4, pix_x4;
  logic [8:0] job_y4, pix_y4;
  logic [7:0] pix_int4;

  always #5 CLK = ~CLK;

  julia_frame_sched #(
    .IMG_W(W), .IMG_H(H), .MAX_ITER(100), .MAX_OUTST(OUTST), .INT_SCALE(2)
  ) dut (
    .CLK(CLK), .RESET(RESET), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .busy(busy), .done(done), .frame_cnt(frame_cnt),
    .job_valid(job_valid), .job_ready(job_ready), .job_z_re(job_z_re), .job_z_im(job_z_im),
    .job_c_re(job_c_re), .job_c_im(job_c_im), .job_x(job_x), .job_y(job_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_iter(res_iter), .res_x(res_x),
    .res_y(res_y), .pix_we(pix_we), .pix_x(pix_x), .pix_y(pix_y), .pix_int(pix_int)
  );

  julia_frame_sched #(
    .IMG_W(W), .IMG_H(H), .MAX_ITER(100), .MAX_OUTST(OUTST), .INT_SCALE(4)
  ) dut4 (
    .CLK(CLK), .RESET(RESET), .cfg_we(1'b0), .cfg_addr(3'd0), .cfg_data(32'd0),
    .start(1'b0), .busy(busy4), .done(done4), .frame_cnt(frame_cnt4),
    .job_valid(job_valid4), .job_ready(1'b0), .job_z_re(job_z_re4), .job_z_im(job_z_im4),
    .job_c_re(job_c_re4), .job_c_im(job_c_im4), .job_x(job_x4), .job_y(job_y4),
    .res_valid(res_valid4), .res_ready(res_ready4), .res_iter(res_iter4), .res_x(res_x4),
    .res_y(res_y4), .pix_we(pix_we4), .pix_x(pix_x4), .pix_y(pix_y4), .pix_int(pix_int4)
  );

  int checks = 0;
  int passed = 0;
  job_t job_q[$];
  pix_t pix_q[$];
  tag_t eng_q[$];
  int iter_tab[NPIX] = '{3, 99, 100, 0, 1, 50, 64, 100, 12, 98, 7, 20};
  int eng_mode = EngNormal;
  int eng_acc = 0;
  int stall_at = -1;
  int ndone = 0;
  logic [31:0] m_c_re = '0, m_c_im = '0, m_re_min = '0, m_im_max = '0, m_step = '0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [7:0] exp_int(input int it);
    if (it >= 100) return 8'd0;
    if (it * 2 > 255) return 8'hFF;
    return 8'(it * 2);
  endfunction

  // Engine model: results 1 cycle after accept (normal), or held / returned newest-first.
  initial begin : engine
    int stall_cnt;
    int pick;
    tag_t t;
    pix_t p;
    stall_cnt = 0;
    forever begin
      @(posedge CLK);
      #1;
      if (RESET) begin
        eng_q.delete();
        res_valid = 1'b0;
        job_ready = 1'b0;
        stall_cnt = 0;
        continue;
      end
      pick = -1;
      if (eng_q.size() > 0) begin
        if (eng_mode == EngNormal) pick = 0;
        else if (eng_mode == EngReverse && (eng_q.size() == OUTST || eng_acc == NPIX))
          pick = eng_q.size() - 1;
      end
      res_valid = (pick >= 0);
      if (pick >= 0) begin
        t = eng_q[pick];
        res_x = t.x;
        res_y = t.y;
        res_iter = 8'(iter_tab[int'(t.y) * W + int'(t.x)]);
        if (res_ready) begin
          p.x = t.x;
          p.y = t.y;
          p.it = exp_int(int'(res_iter));
          pix_q.push_back(p);
          eng_q.delete(pick);
        end
      end
      job_ready = (stall_cnt == 0) && !(eng_mode == EngStop4 && eng_acc >= 4);
      if (stall_cnt > 0) stall_cnt--;
      if (job_valid && job_ready) begin
        t.x = job_x;
        t.y = job_y;
        eng_q.push_back(t);
        eng_acc++;
        if (eng_acc == stall_at) stall_cnt = 5;
      end
    end
  end

  initial begin : monitor
    int outst_tb;
    int njobs;
    int npix;
    logic prev_stall;
    pix_t e;
    outst_tb = 0;
    njobs = 0;
    npix = 0;
    prev_stall = 1'b0;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        outst_tb = 0;
        njobs = 0;
        npix = 0;
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) check("valid_held", job_valid, 1'b1);
      if (job_valid) begin
        if (job_q.size() == 0) check("job_extra", job_valid, 1'b0);
        else begin
          check("job_fields", {job_x, job_y, job_z_re, job_z_im, job_c_re, job_c_im}, job_q[0]);
          if (job_ready) begin
            void'(job_q.pop_front());
            njobs++;
          end
        end
      end
      prev_stall = job_valid && !job_ready;
      if (outst_tb >= OUTST) check("valid_at_max_outst", job_valid, 1'b0);
      if (job_valid && job_ready) outst_tb++;
      if (res_valid && res_ready) outst_tb--;
      if (pix_we) begin
        if (pix_q.size() == 0) check("pix_extra", pix_we, 1'b0);
        else begin
          e = pix_q.pop_front();
          check("pix_write", {pix_x, pix_y, pix_int}, e);
          npix++;
        end
      end
      if (done) begin
        check("pix_before_done", npix, NPIX);
        check("jobs_before_done", njobs, NPIX);
        ndone++;
        npix = 0;
        njobs = 0;
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    step();
    cfg_we = 1'b0;
    case (a)
      3'd0: m_c_re = d;
      3'd1: m_c_im = d;
      3'd2: m_re_min = d;
      3'd3: m_im_max = d;
      3'd4: m_step = d;
      default: ;
    endcase
  endtask

  task automatic push_frame_jobs();
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        job_t j;
        j.x = 10'(x);
        j.y = 9'(y);
        j.z_re = m_re_min + 32'(x) * m_step;
        j.z_im = m_im_max - 32'(y) * m_step;
        j.c_re = m_c_re;
        j.c_im = m_c_im;
        job_q.push_back(j);
      end
    end
  endtask

  task automatic run_frame(input int mode, input int stall, input bit midframe,
                           input int exp_cnt);
    bit got;
    int hold_cnt;
    int done_before;
    push_frame_jobs();
    eng_mode = mode;
    eng_acc = 0;
    stall_at = stall;
    done_before = ndone;
    start = 1'b1;
    step();
    start = 1'b0;
    got = 1'b0;
    hold_cnt = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      if (i == 2) check("busy_in_frame", busy, 1'b1);
      if (midframe && i == 6) begin
        start = 1'b1;
        cfg_write(3'd0, 32'h0040_0000);
        start = 1'b0;
      end
      if (eng_mode == EngHold && eng_q.size() == OUTST) begin
        hold_cnt++;
        if (hold_cnt == 12) eng_mode = EngNormal;
      end
      if (done) got = 1'b1;
      else step();
    end
    check("done_seen", got, 1'b1);
    step();
    check("frame_cnt", frame_cnt, 16'(exp_cnt));
    check("busy_after_done", busy, 1'b0);
    check("done_one_cycle", done, 1'b0);
    repeat (3) step();
    check("done_pulses", ndone - done_before, 1);
  endtask

  initial begin : main
    bit ok;
    repeat (3) step();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_frame_cnt", frame_cnt, 16'd0);
    check("rst_job_valid", job_valid, 1'b0);
    check("rst_pix", {pix_we, pix_x, pix_y, pix_int}, 28'd0);
    check("rst_res_ready", res_ready, 1'b0);
    check("rst_job_data", {job_z_re, job_z_im, job_c_re, job_c_im, job_x, job_y}, 147'd0);
    RESET = 1'b0;
    step();
    check("res_ready_after_rst", res_ready, 1'b1);

    cfg_write(3'd0, 32'hFF40_0000);
    cfg_write(3'd1, 32'h0020_0000);
    cfg_write(3'd2, 32'hFE00_0000);
    cfg_write(3'd3, 32'h0100_0000);
    cfg_write(3'd4, 32'h0080_0000);
    // Unused address must not disturb any shadow register.
    cfg_we = 1'b1;
    cfg_addr = 3'd5;
    cfg_data = 32'hDEAD_BEEF;
    step();
    cfg_we = 1'b0;
    step();

    run_frame(EngNormal, -1, 1'b0, 1);
    run_frame(EngNormal, 5, 1'b1, 2);
    run_frame(EngHold, -1, 1'b0, 3);
    run_frame(EngReverse, -1, 1'b0, 4);

    // Reset with 4 jobs in flight.
    push_frame_jobs();
    eng_mode = EngStop4;
    eng_acc = 0;
    stall_at = -1;
    start = 1'b1;
    step();
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (eng_q.size() == 4) ok = 1'b1;
      else step();
    end
    check("four_in_flight", ok, 1'b1);
    step();
    RESET = 1'b1;
    step();
    check("mid_rst_busy_done", {busy, done}, 2'b00);
    check("mid_rst_frame_cnt", frame_cnt, 16'd0);
    check("mid_rst_job_valid", job_valid, 1'b0);
    check("mid_rst_pix", {pix_we, pix_x, pix_y, pix_int}, 28'd0);
    check("mid_rst_res_ready", res_ready, 1'b0);
    check("mid_rst_job_data", {job_z_re, job_z_im, job_c_re, job_c_im, job_x, job_y}, 147'd0);
    RESET = 1'b0;
    job_q.delete();
    pix_q.delete();
    eng_mode = EngNormal;
    step();
    step();
    // Config shadows were cleared by reset; reload before recovering.
    cfg_write(3'd0, 32'hFF40_0000);
    cfg_write(3'd1, 32'h0020_0000);
    cfg_write(3'd2, 32'hFE00_0000);
    cfg_write(3'd3, 32'h0100_0000);
    cfg_write(3'd4, 32'h0080_0000);
    run_frame(EngNormal, -1, 1'b0, 1);

    // Linear shading saturation with INT_SCALE=4.
    res_valid4 = 1'b1;
    res_iter4 = 8'd99;
    res_x4 = 10'd3;
    res_y4 = 9'd2;
    step();
    res_iter4 = 8'd50;
    res_x4 = 10'd1;
    res_y4 = 9'd0;
    check("scale4_iter99", {pix_we4, pix_x4, pix_y4, pix_int4}, {1'b1, 10'd3, 9'd2, 8'd255});
    step();
    res_valid4 = 1'b0;
    check("scale4_iter50", {pix_we4, pix_x4, pix_y4, pix_int4}, {1'b1, 10'd1, 9'd0, 8'd200});
    step();
    check("scale4_we_clear", pix_we4, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
